// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: handshake and control bundle between the multicycle control unit and datapath/caches
// master: control unit side (consumes ihit/dhit/InstrOp/InstrFunc/Equal, drives controls, requests, status, counters)
// slave:  datapath/cache side (the mirror image)
interface multicycle_control_unit_if #(parameter int PERF_W = 32);
   logic ihit, dhit, Equal;
   logic [5:0] InstrOp, InstrFunc;
   logic PcWEN, IrWEN, iMemRe, dMemRe, dMemWr;
   logic PcSrc, RegDst, MemToReg, regWEN, UpperImm, AluSrc, ExtOp, JType, RegZero, JReg;
   logic [3:0] AluOp;
   logic Halt, timeout;
   logic [2:0] state_o;
   logic [PERF_W-1:0] cycle_cnt, instr_cnt;
   modport master (
      input ihit, dhit, Equal, InstrOp, InstrFunc,
      output PcWEN, IrWEN, iMemRe, dMemRe, dMemWr, PcSrc, RegDst, MemToReg, regWEN, UpperImm,
         AluSrc, ExtOp, JType, RegZero, JReg, AluOp, Halt, timeout, state_o, cycle_cnt, instr_cnt
   );
   modport slave (
      output ihit, dhit, Equal, InstrOp, InstrFunc,
      input PcWEN, IrWEN, iMemRe, dMemRe, dMemWr, PcSrc, RegDst, MemToReg, regWEN, UpperImm,
         AluSrc, ExtOp, JType, RegZero, JReg, AluOp, Halt, timeout, state_o, cycle_cnt, instr_cnt
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for the multicycle MIPS datapath
// Ports: CLK (rising edge), nRST (async active-low), cu (master modport): ihit/dhit/InstrOp/InstrFunc/Equal in;
//        datapath controls, PcWEN/IrWEN, memory requests, Halt/timeout, state_o, cycle_cnt/instr_cnt out
module multicycle_control_unit #(
   parameter bit TIMEOUT_EN  = 1'b1,
   parameter int TIMEOUT_CYC = 1024,
   parameter int PERF_W      = 32
) (
   input logic CLK,
   input logic nRST,
   multicycle_control_unit_if.master cu
);
   typedef enum logic [2:0] {RESET, FETCH, DECODE, EXEC, MEM, WB, HALTED} state_t;
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
      OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
      OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20, FN_ADDU = 6'h21,
      FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
      FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
   localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3, ALU_AND = 4'd4,
      ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
   localparam int WW = $clog2(TIMEOUT_CYC);
   state_t state, nxt;
   logic [WW-1:0] wcnt;
   logic [PERF_W-1:0] cyc, ins;
   logic to_q, hit, waiting, wd_fire, is_r, is_alui, is_mem, is_br, is_lw;
   logic [3:0] alu_fn, alu_i;
   assign is_r    = cu.InstrOp == OP_R;
   assign is_alui = cu.InstrOp[5:3] == 3'b001;
   assign is_lw   = cu.InstrOp == OP_LW;
   assign is_mem  = is_lw || cu.InstrOp == OP_SW;
   assign is_br   = cu.InstrOp == OP_BEQ || cu.InstrOp == OP_BNE;
   // watchdog only runs while a memory request is outstanding and unanswered
   assign hit     = state == FETCH ? cu.ihit : cu.dhit;
   assign waiting = (state == FETCH || state == MEM) && !hit;
   assign wd_fire = TIMEOUT_EN && waiting && wcnt == WW'(TIMEOUT_CYC - 1);
   assign alu_i = is_br ? ALU_SUB : cu.InstrOp == OP_SLTI ? ALU_SLT : cu.InstrOp == OP_SLTIU ? ALU_SLTU :
                  cu.InstrOp == OP_ANDI ? ALU_AND : cu.InstrOp == OP_ORI ? ALU_OR :
                  cu.InstrOp == OP_XORI ? ALU_XOR : ALU_ADD;
   always_comb begin
      alu_fn = ALU_ADD;
      case (cu.InstrFunc)
         FN_SLL:          alu_fn = ALU_SLL;
         FN_SRL:          alu_fn = ALU_SRL;
         FN_ADD, FN_ADDU: alu_fn = ALU_ADD;
         FN_SUB, FN_SUBU: alu_fn = ALU_SUB;
         FN_AND:          alu_fn = ALU_AND;
         FN_OR:           alu_fn = ALU_OR;
         FN_XOR:          alu_fn = ALU_XOR;
         FN_NOR:          alu_fn = ALU_NOR;
         FN_SLT:          alu_fn = ALU_SLT;
         FN_SLTU:         alu_fn = ALU_SLTU;
         default:         alu_fn = ALU_ADD;
      endcase
   end
   always_comb begin
      nxt = state;
      cu.PcWEN = 1'b0;
      cu.IrWEN = 1'b0;
      cu.iMemRe = 1'b0;
      cu.dMemRe = 1'b0;
      cu.dMemWr = 1'b0;
      cu.PcSrc = 1'b0;
      cu.RegDst = 1'b0;
      cu.MemToReg = 1'b0;
      cu.regWEN = 1'b0;
      cu.UpperImm = 1'b0;
      cu.AluSrc = 1'b0;
      cu.ExtOp = 1'b0;
      cu.JType = 1'b0;
      cu.RegZero = 1'b0;
      cu.JReg = 1'b0;
      cu.AluOp = '0;
      cu.Halt = 1'b0;
      case (state)
         RESET: nxt = FETCH;
         FETCH: begin
            cu.iMemRe = 1'b1;
            cu.IrWEN = cu.ihit;
            nxt = cu.ihit ? DECODE : wd_fire ? HALTED : FETCH;
         end
         DECODE: begin
            if (cu.InstrOp == OP_HALT) nxt = HALTED;
            else if (cu.InstrOp == OP_J || cu.InstrOp == OP_JAL) begin
               cu.JType = 1'b1;
               cu.PcWEN = 1'b1;
               cu.regWEN = cu.InstrOp == OP_JAL;
               cu.RegZero = cu.InstrOp == OP_JAL;
               nxt = FETCH;
            end else if (is_r && cu.InstrFunc == FN_JR) begin
               cu.JReg = 1'b1;
               cu.PcWEN = 1'b1;
               nxt = FETCH;
            end else nxt = EXEC;
         end
         EXEC: begin
            cu.AluOp = is_r ? alu_fn : alu_i;
            cu.AluSrc = is_alui || is_mem;
            // ADDI/ADDIU/SLTI/SLTIU sign-extend; ANDI/ORI/XORI/LUI zero-extend
            cu.ExtOp = is_mem || is_br || (is_alui && !cu.InstrOp[2]);
            cu.UpperImm = cu.InstrOp == OP_LUI;
            // BNE differs from BEQ only in opcode bit 0, which inverts the compare
            cu.PcSrc = is_br && (cu.Equal ^ cu.InstrOp[0]);
            cu.PcWEN = !(is_r || is_alui || is_mem);
            nxt = is_mem ? MEM : (is_r || is_alui) ? WB : FETCH;
         end
         MEM: begin
            cu.dMemRe = is_lw;
            cu.dMemWr = !is_lw;
            cu.PcWEN = cu.dhit && !is_lw;
            nxt = cu.dhit ? (is_lw ? WB : FETCH) : wd_fire ? HALTED : MEM;
         end
         WB: begin
            cu.regWEN = 1'b1;
            cu.RegDst = is_r;
            cu.MemToReg = is_lw;
            cu.PcWEN = 1'b1;
            nxt = FETCH;
         end
         HALTED: cu.Halt = 1'b1;
         default: nxt = RESET;
      endcase
   end
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         state <= RESET;
         wcnt <= '0;
         to_q <= 1'b0;
         cyc <= '0;
         ins <= '0;
      end else begin
         state <= nxt;
         wcnt <= waiting ? wcnt + 1'b1 : '0;
         if (wd_fire) to_q <= 1'b1;
         if (state != RESET && state != HALTED && ~&cyc) cyc <= cyc + 1'b1;
         if (cu.PcWEN && ~&ins) ins <= ins + 1'b1;
      end
   assign cu.timeout = to_q;
   assign cu.state_o = state;
   assign cu.cycle_cnt = cyc;
   assign cu.instr_cnt = ins;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed scenario bench for the multicycle control unit
module tb_multicycle_control_unit;
   localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
      OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   int errors = 0;
   int checks = 0;
   multicycle_control_unit_if #(.PERF_W(32)) m ();
   multicycle_control_unit_if #(.PERF_W(4)) n ();
   multicycle_control_unit #(.TIMEOUT_EN(1'b1), .TIMEOUT_CYC(8), .PERF_W(32)) dut (.CLK(CLK), .nRST(nRST), .cu(m.master));
   multicycle_control_unit #(.TIMEOUT_EN(1'b1), .TIMEOUT_CYC(8), .PERF_W(4)) dut4 (.CLK(CLK), .nRST(nRST), .cu(n.master));
   // narrow-counter instance runs a stream of back-to-back J instructions
   assign n.ihit = 1'b1;
   assign n.dhit = 1'b0;
   assign n.Equal = 1'b0;
   assign n.InstrOp = OP_J;
   assign n.InstrFunc = 6'h00;
   always #5 CLK = ~CLK;

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      m.ihit = 1'b1; m.dhit = 1'b1; m.Equal = 1'b0; m.InstrOp = OP_ADDI; m.InstrFunc = 6'h00;
      repeat (2) @(negedge CLK);
      #1;
      checks++; if (m.state_o !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", m.state_o); end
      checks++; if ({m.Halt, m.timeout, m.iMemRe, m.PcWEN, m.IrWEN} !== 5'b0) begin errors++; $display("FAIL reset_outs got=%b exp=00000", {m.Halt, m.timeout, m.iMemRe, m.PcWEN, m.IrWEN}); end
      checks++; if (m.cycle_cnt !== 32'd0 || m.instr_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", m.cycle_cnt, m.instr_cnt); end
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_alu_halt();
      logic [2:0] es [7] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd6};
      logic [5:0] os [7] = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_HALT, OP_HALT, OP_HALT};
      m.ihit = 1'b1; m.dhit = 1'b0; m.InstrOp = OP_ADDI;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         @(negedge CLK);
         m.InstrOp = os[k];
         #1;
         checks++; if (m.state_o !== es[k]) begin errors++; $display("FAIL alu_state k=%0d got=%0d exp=%0d", k, m.state_o, es[k]); end
         if (k == 2) begin
            checks++; if ({m.AluOp, m.AluSrc, m.ExtOp, m.PcWEN} !== {4'd2, 3'b110}) begin errors++; $display("FAIL alu_exec got=%h/%b%b%b exp=2/110", m.AluOp, m.AluSrc, m.ExtOp, m.PcWEN); end
         end
         if (k == 3) begin
            checks++; if ({m.regWEN, m.RegDst, m.MemToReg, m.PcWEN} !== 4'b1001) begin errors++; $display("FAIL alu_wb got=%b exp=1001", {m.regWEN, m.RegDst, m.MemToReg, m.PcWEN}); end
         end
      end
      checks++; if (m.Halt !== 1'b1 || m.timeout !== 1'b0) begin errors++; $display("FAIL halt_flags got=%b%b exp=10", m.Halt, m.timeout); end
      checks++; if (m.instr_cnt !== 32'd1) begin errors++; $display("FAIL halt_instr got=%0d exp=1", m.instr_cnt); end
      checks++; if (m.cycle_cnt !== 32'd6) begin errors++; $display("FAIL halt_cycles got=%0d exp=6", m.cycle_cnt); end
      repeat (3) @(negedge CLK);
      #1;
      checks++; if (m.state_o !== 3'd6 || m.iMemRe !== 1'b0 || m.cycle_cnt !== 32'd6) begin errors++; $display("FAIL halt_absorb got=%0d/%b/%0d exp=6/0/6", m.state_o, m.iMemRe, m.cycle_cnt); end
   endtask

   task automatic test_lw_waits();
      logic [2:0] es [11] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
      int ire = 0;
      int dre = 0;
      int dwr = 0;
      m.ihit = 1'b0; m.dhit = 1'b0; m.InstrOp = OP_LW;
      do_reset();
      for (int k = 0; k < 11; k++) begin
         @(negedge CLK);
         m.ihit = k == 3;
         m.dhit = k == 8;
         #1;
         checks++; if (m.state_o !== es[k]) begin errors++; $display("FAIL lw_state k=%0d got=%0d exp=%0d", k, m.state_o, es[k]); end
         if (k < 10) begin
            ire += int'(m.iMemRe);
            dre += int'(m.dMemRe);
            dwr += int'(m.dMemWr);
         end
         if (k == 3) begin
            checks++; if (m.IrWEN !== 1'b1) begin errors++; $display("FAIL lw_irwen got=%b exp=1", m.IrWEN); end
         end
         if (k == 5) begin
            checks++; if ({m.AluOp, m.AluSrc, m.ExtOp} !== {4'd2, 2'b11}) begin errors++; $display("FAIL lw_exec got=%h/%b%b exp=2/11", m.AluOp, m.AluSrc, m.ExtOp); end
         end
         if (k == 9) begin
            checks++; if ({m.regWEN, m.MemToReg, m.RegDst, m.PcWEN} !== 4'b1101) begin errors++; $display("FAIL lw_wb got=%b exp=1101", {m.regWEN, m.MemToReg, m.RegDst, m.PcWEN}); end
         end
      end
      checks++; if (ire != 4 || dre != 3 || dwr != 0) begin errors++; $display("FAIL lw_req_cycles got=%0d/%0d/%0d exp=4/3/0", ire, dre, dwr); end
      checks++; if (m.instr_cnt !== 32'd1) begin errors++; $display("FAIL lw_instr got=%0d exp=1", m.instr_cnt); end
   endtask

   task automatic test_branches();
      logic [2:0] es [7] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1};
      int pcw = 0;
      m.ihit = 1'b1; m.dhit = 1'b0; m.Equal = 1'b1; m.InstrOp = OP_BEQ;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         @(negedge CLK);
         m.InstrOp = k < 3 ? OP_BEQ : OP_BNE;
         #1;
         checks++; if (m.state_o !== es[k]) begin errors++; $display("FAIL br_state k=%0d got=%0d exp=%0d", k, m.state_o, es[k]); end
         if (k < 6) pcw += int'(m.PcWEN);
         if (k == 2) begin
            checks++; if ({m.PcSrc, m.AluOp, m.ExtOp} !== {1'b1, 4'd3, 1'b1}) begin errors++; $display("FAIL beq_exec got=%b/%h/%b exp=1/3/1", m.PcSrc, m.AluOp, m.ExtOp); end
         end
         if (k == 5) begin
            checks++; if (m.PcSrc !== 1'b0) begin errors++; $display("FAIL bne_pcsrc got=%b exp=0", m.PcSrc); end
         end
      end
      checks++; if (pcw != 2 || m.instr_cnt !== 32'd2) begin errors++; $display("FAIL br_pcwen got=%0d/%0d exp=2/2", pcw, m.instr_cnt); end
   endtask

   task automatic test_timeout();
      m.ihit = 1'b0; m.dhit = 1'b0; m.InstrOp = OP_ADDI;
      do_reset();
      repeat (8) @(negedge CLK);
      #1;
      checks++; if (m.state_o !== 3'd1 || m.iMemRe !== 1'b1 || m.timeout !== 1'b0) begin errors++; $display("FAIL to_lastwait got=%0d/%b/%b exp=1/1/0", m.state_o, m.iMemRe, m.timeout); end
      @(negedge CLK);
      #1;
      checks++; if (m.state_o !== 3'd6 || m.timeout !== 1'b1 || m.Halt !== 1'b1) begin errors++; $display("FAIL to_fire got=%0d/%b/%b exp=6/1/1", m.state_o, m.timeout, m.Halt); end
      repeat (2) @(negedge CLK);
      #1;
      checks++; if (m.iMemRe !== 1'b0 || m.timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b/%b exp=0/1", m.iMemRe, m.timeout); end
   endtask

   task automatic test_hit_at_limit();
      m.ihit = 1'b0; m.dhit = 1'b0; m.InstrOp = OP_ADDI;
      do_reset();
      #1;
      checks++; if (m.timeout !== 1'b0) begin errors++; $display("FAIL lim_reset_to got=%b exp=0", m.timeout); end
      repeat (7) @(negedge CLK);
      @(negedge CLK);
      m.ihit = 1'b1;
      #1;
      checks++; if (m.state_o !== 3'd1 || m.IrWEN !== 1'b1) begin errors++; $display("FAIL lim_hit got=%0d/%b exp=1/1", m.state_o, m.IrWEN); end
      @(negedge CLK);
      #1;
      checks++; if (m.state_o !== 3'd2 || m.timeout !== 1'b0) begin errors++; $display("FAIL lim_decode got=%0d/%b exp=2/0", m.state_o, m.timeout); end
   endtask

   task automatic test_sw_reset_and_saturate();
      m.ihit = 1'b1; m.dhit = 1'b0; m.InstrOp = OP_SW;
      do_reset();
      repeat (4) @(negedge CLK);
      #1;
      checks++; if (m.state_o !== 3'd4 || m.dMemWr !== 1'b1 || m.dMemRe !== 1'b0) begin errors++; $display("FAIL sw_mem got=%0d/%b/%b exp=4/1/0", m.state_o, m.dMemWr, m.dMemRe); end
      #2 nRST = 1'b0;
      #1;
      checks++; if (m.dMemWr !== 1'b0 || m.state_o !== 3'd0) begin errors++; $display("FAIL sw_async got=%b/%0d exp=0/0", m.dMemWr, m.state_o); end
      checks++; if (m.cycle_cnt !== 32'd0 || m.instr_cnt !== 32'd0) begin errors++; $display("FAIL sw_cnt_clr got=%0d/%0d exp=0/0", m.cycle_cnt, m.instr_cnt); end
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      #1;
      checks++; if (m.state_o !== 3'd1 || m.cycle_cnt !== 32'd0) begin errors++; $display("FAIL sw_restart got=%0d/%0d exp=1/0", m.state_o, m.cycle_cnt); end
      repeat (20) @(negedge CLK);
      #1;
      checks++; if (n.instr_cnt !== 4'd10) begin errors++; $display("FAIL sat_mid got=%0d exp=10", n.instr_cnt); end
      repeat (20) @(negedge CLK);
      #1;
      checks++; if (n.instr_cnt !== 4'd15 || n.cycle_cnt !== 4'd15) begin errors++; $display("FAIL sat_end got=%0d/%0d exp=15/15", n.instr_cnt, n.cycle_cnt); end
   endtask

   initial begin
      test_reset();
      test_alu_halt();
      test_lw_waits();
      test_branches();
      test_timeout();
      test_hit_at_limit();
      test_sw_reset_and_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
